mysystem_clk_enable_gen: RTL

//  Multi-channel, run-time reconfigurable clock-enable generator; digital successor to the fixed two-output

---
 rtl/mysystem_clkgen_pkg.sv | 21 ++
 rtl/mysystem_clkgen_channel.sv | 68 ++++++
 rtl/mysystem_clk_enable_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/mysystem_clkgen_pkg.sv
// rtl/mysystem_clkgen_pkg.sv - shared types and width helpers for the clock-enable generator
package mysystem_clkgen_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALIGN  = 2'd1,
        S_SETTLE = 2'd2,
        S_LOCKED = 2'd3
    } clkgen_state_t;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Width able to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/mysystem_clkgen_channel.sv
// rtl/mysystem_clkgen_channel.sv - one divider channel: shadow config, phase counter, registered strobe/level
module mysystem_clkgen_channel
    import mysystem_clkgen_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 1
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             run_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] phase_i,
    output logic             en_o,
    output logic             lvl_o
);

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'((DEF_DIV < 1) ? 1 : DEF_DIV);

    logic [DIV_W-1:0] div_q, ph_q, cnt_q, cnt_d;
    logic [DIV_W-1:0] wr_div, wr_last, wr_ph;
    logic [DIV_W-1:0] div_last, half;
    logic             en_q, en_d, lvl_q, lvl_d;

    // Shadow values are normalised on write so the counter never sees div=0 or phase>=div.
    always_comb begin
        wr_div  = (div_i == '0) ? ONE : div_i;
        wr_last = wr_div - ONE;
        wr_ph   = (phase_i > wr_last) ? wr_last : phase_i;
    end

    always_comb begin
        div_last = div_q - ONE;
        half     = div_q >> 1;
        cnt_d    = cnt_q;
        if (load_i) begin
            cnt_d = div_last - ph_q;
        end else if (run_i) begin
            cnt_d = (cnt_q == div_last) ? '0 : cnt_q + ONE;
        end
        en_d  = run_i && (cnt_q == div_last);
        lvl_d = run_i && (cnt_q < half);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= RST_DIV;
            ph_q  <= '0;
            cnt_q <= '0;
            en_q  <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            if (wr_i) begin
                div_q <= wr_div;
                ph_q  <= wr_ph;
            end
            cnt_q <= cnt_d;
            en_q  <= en_d;
            lvl_q <= lvl_d;
        end
    end

    assign en_o  = en_q;
    assign lvl_o = lvl_q;

endmodule

// File: rtl/mysystem_clk_enable_gen.sv
// rtl/mysystem_clk_enable_gen.sv - multi-channel reconfigurable clock-enable generator with lock tracking
module mysystem_clk_enable_gen
    import mysystem_clkgen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 1,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk_en,
    output logic [NUM_CH-1:0] outclk_lvl,
    output logic              locked
);

    localparam int             SET_W    = cnt_width(LOCK_CYCLES);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

    clkgen_state_t    state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             ready_q, err_q, locked_q;
    logic             accept, in_range, cfg_hit;
    logic             load, run;

    assign accept   = cfg_valid && ready_q;
    assign in_range = (32'(cfg_ch) < NUM_CH);
    assign cfg_hit  = accept && in_range;
    assign load     = (state_q == S_ALIGN);
    assign run      = (state_q == S_SETTLE) || (state_q == S_LOCKED);

    // A valid config while running forces a realign; dropping enable overrides everything.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ALIGN;
            end
            S_ALIGN: begin
                state_d  = S_SETTLE;
                settle_d = '0;
            end
            S_SETTLE: begin
                if (settle_q == SET_LAST) state_d = S_LOCKED;
                else                      settle_d = settle_q + SET_W'(1);
                if (cfg_hit) state_d = S_ALIGN;
            end
            S_LOCKED: begin
                if (cfg_hit) state_d = S_ALIGN;
            end
            default: state_d = S_IDLE;
        endcase
        if (!enable && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            ready_q  <= (state_d != S_ALIGN);
            err_q    <= accept && !in_range;
            locked_q <= (state_d == S_LOCKED);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mysystem_clkgen_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .refclk  (refclk),
            .rst_n   (rst_n),
            .load_i  (load),
            .run_i   (run),
            .wr_i    (cfg_hit && (cfg_ch == CH_W'(c))),
            .div_i   (cfg_div),
            .phase_i (cfg_phase),
            .en_o    (outclk_en[c]),
            .lvl_o   (outclk_lvl[c])
        );
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign locked    = locked_q;

endmodule
